// File: rtl/riscv_pkg.sv
// Shared front-end types and defaults for the instruction fetch path.
// The fetch-queue entry layout and the PC increment helper live here.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  // Wide enough for any realistic backlog of responses owed to squashed fetches.
  localparam int DROP_W = 16;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: a slot is allocated at request acceptance, filled when its
// response returns, and freed by the decode handshake.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            alloc_en,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill_en,
  input  logic [XLEN-1:0] fill_instr,
  input  logic            pop_en,
  output fetch_entry_t    head_entry,
  output logic [PW-1:0]   unfilled,
  output logic            full,
  output logic            empty
);

  fetch_entry_t  entries [DEPTH];
  logic [PW-1:0] alloc_ptr_r;
  logic [PW-1:0] fill_ptr_r;
  logic [PW-1:0] head_ptr_r;
  logic [PW-1:0] count_s;

  // Occupancy flags derived from the extra wrap bit on each pointer.
  always_comb begin
    count_s    = alloc_ptr_r - head_ptr_r;
    unfilled   = alloc_ptr_r - fill_ptr_r;
    full       = (count_s == PW'(DEPTH));
    empty      = (alloc_ptr_r == head_ptr_r);
    head_entry = entries[head_ptr_r[AW-1:0]];
  end

  // Pointer and entry storage update; a flush drops every slot at once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      alloc_ptr_r <= '0;
      fill_ptr_r  <= '0;
      head_ptr_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (flush) begin
      alloc_ptr_r <= '0;
      fill_ptr_r  <= '0;
      head_ptr_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].filled <= 1'b0;
      end
    end else begin
      if (alloc_en) begin
        entries[alloc_ptr_r[AW-1:0]].pc     <= alloc_pc;
        entries[alloc_ptr_r[AW-1:0]].filled <= 1'b0;
        alloc_ptr_r <= alloc_ptr_r + PW'(1);
      end
      if (fill_en) begin
        entries[fill_ptr_r[AW-1:0]].instr  <= fill_instr;
        entries[fill_ptr_r[AW-1:0]].filled <= 1'b1;
        fill_ptr_r <= fill_ptr_r + PW'(1);
      end
      if (pop_en) begin
        head_ptr_r <= head_ptr_r + PW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// IF stage: PC generation, decoupled in-order imem req/rsp port and a fetch queue
// feeding decode; EX redirects flush the queue and squash in-flight responses.
module fetch_queue_stage #(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = riscv_pkg::RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_req_ready_i,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [XLEN-1:0] dec_instr_o,
  output logic [XLEN-1:0] dec_pc_o,
  output logic [XLEN-1:0] dec_pc_plus4_o
);

  import riscv_pkg::*;

  localparam int PW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   pc_r;
  logic [DROP_W-1:0] drop_cnt_r;
  fetch_entry_t      head_entry;
  logic [PW-1:0]     unfilled;
  logic              full;
  logic              empty;
  logic              dec_valid_s;
  logic              pop_s;
  logic              req_valid_s;
  logic              req_fire_s;
  logic              rsp_drop_s;
  logic              fill_s;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_i),
    .alloc_en   (req_fire_s),
    .alloc_pc   (pc_r),
    .fill_en    (fill_s),
    .fill_instr (imem_rsp_data_i),
    .pop_en     (pop_s),
    .head_entry (head_entry),
    .unfilled   (unfilled),
    .full       (full),
    .empty      (empty)
  );

  // Request gating and response routing; a full queue may still issue when its head pops this cycle.
  always_comb begin
    dec_valid_s = head_entry.filled & ~empty;
    pop_s       = dec_valid_s & dec_ready_i & ~redirect_i;
    req_valid_s = rst & ~redirect_i & (~full | (dec_valid_s & dec_ready_i));
    req_fire_s  = req_valid_s & imem_req_ready_i;
    rsp_drop_s  = imem_rsp_valid_i & (drop_cnt_r != '0);
    fill_s      = imem_rsp_valid_i & (drop_cnt_r == '0) & ~redirect_i;
  end

  // Decode-side view of the queue head.
  always_comb begin
    imem_req_valid_o = req_valid_s;
    imem_req_addr_o  = pc_r;
    dec_valid_o      = dec_valid_s;
    dec_pc_o         = head_entry.pc;
    dec_pc_plus4_o   = pc_plus4(head_entry.pc);
    if (dec_valid_s) begin
      dec_instr_o = head_entry.instr;
    end else begin
      dec_instr_o = NOP_INSTR;
    end
  end

  // PC and squash counter. On redirect every response still owed (old backlog plus
  // unfilled slots) must be dropped, less the one arriving and discarded right now.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r       <= RESET_PC;
      drop_cnt_r <= '0;
    end else if (redirect_i) begin
      pc_r       <= redirect_pc_i & {{(XLEN-2){1'b1}}, 2'b00};
      drop_cnt_r <= drop_cnt_r + DROP_W'(unfilled) - DROP_W'(imem_rsp_valid_i);
    end else begin
      if (req_fire_s) begin
        pc_r <= pc_r + 32'd4;
      end
      if (rsp_drop_s) begin
        drop_cnt_r <= drop_cnt_r - DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Randomized bench for fetch_queue_stage: an in-order memory model with random latency
// and an epoch-tagged queue reference model of what decode should see.
module tb_fetch_queue_stage;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus4;

  always #5 clk = ~clk;

  fetch_queue_stage #(
    .XLEN      (32),
    .DEPTH     (DEPTH),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirect_pc),
    .imem_req_valid_o (req_valid),
    .imem_req_addr_o  (req_addr),
    .imem_req_ready_i (req_ready),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .dec_valid_o      (dec_valid),
    .dec_ready_i      (dec_ready),
    .dec_instr_o      (dec_instr),
    .dec_pc_o         (dec_pc),
    .dec_pc_plus4_o   (dec_pc_plus4)
  );

  typedef struct {
    logic [31:0] pc;
    bit          filled;
  } ment_t;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  ment_t       entries [$];
  mreq_t       mem_q [$];
  int          epoch, cyc, last_due, n_cmp, n_bad, n_acc;
  logic [31:0] exp_fetch;
  int          p_redir, p_ready, p_dec, lat_lo, lat_hi;
  bit          force_redir;
  logic [31:0] force_pc;
  logic [31:0] first_hs_pc;
  bit          hs_seen;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = 32'd0; dec_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_req_addr", req_addr, 32'd0);
    chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_dec_instr", dec_instr, NOP);
    chk("rst_dec_pc", dec_pc, 32'd0);
    chk("rst_dec_pc4", dec_pc_plus4, 32'd4);
    entries.delete();
    mem_q.delete();
    epoch++;
    exp_fetch = 32'd0;
    last_due  = 0;
  endtask

  task automatic step();
    logic [31:0] r;
    bit          rsp, exp_dv, exp_rv, hs, done;
    int          due;
    mreq_t       m;
    @(negedge clk);
    rst = 1'b1;
    r = $urandom();
    redirect    = force_redir || ($urandom_range(999) < p_redir);
    redirect_pc = force_redir ? force_pc : {r[31:2], 2'b00};
    force_redir = 1'b0;
    req_ready   = ($urandom_range(99) < p_ready);
    dec_ready   = ($urandom_range(99) < p_dec);
    rsp         = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rsp_valid   = rsp;
    rsp_data    = rsp ? instr_of(mem_q[0].addr) : $urandom();
    #1;
    exp_dv = (entries.size() > 0) && entries[0].filled;
    exp_rv = !redirect && ((entries.size() < DEPTH) || (exp_dv && dec_ready));
    hs     = exp_dv && dec_ready && !redirect;
    chk("dec_valid", {31'd0, dec_valid}, {31'd0, exp_dv});
    if (exp_dv) begin
      chk("dec_pc", dec_pc, entries[0].pc);
      chk("dec_instr", dec_instr, instr_of(entries[0].pc));
      chk("dec_pc_plus4", dec_pc_plus4, entries[0].pc + 32'd4);
    end else begin
      chk("bubble_instr", dec_instr, NOP);
    end
    chk("req_valid", {31'd0, req_valid}, {31'd0, exp_rv});
    if (exp_rv) chk("req_addr", req_addr, exp_fetch);
    if (hs && !hs_seen) begin
      first_hs_pc = dec_pc;
      hs_seen     = 1'b1;
    end
    // Reference update for the coming edge.
    if (rsp) begin
      m = mem_q.pop_front();
      if (!redirect && m.epoch == epoch) begin
        done = 1'b0;
        foreach (entries[i]) begin
          if (!done && !entries[i].filled) begin
            entries[i].filled = 1'b1;
            done = 1'b1;
          end
        end
      end
    end
    if (redirect) begin
      entries.delete();
      epoch++;
      exp_fetch = redirect_pc;
    end else begin
      if (hs) void'(entries.pop_front());
      if (exp_rv && req_ready) begin
        due = cyc + int'($urandom_range(lat_hi, lat_lo));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{exp_fetch, epoch, due});
        entries.push_back('{exp_fetch, 1'b0});
        exp_fetch = exp_fetch + 32'd4;
        n_acc++;
      end
    end
    cyc++;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_acc = 0; epoch = 0; cyc = 0; last_due = 0;
    p_redir = 0; p_ready = 100; p_dec = 100; lat_lo = 1; lat_hi = 1;
    force_redir = 1'b0; force_pc = 32'd0; first_hs_pc = 32'd0; hs_seen = 1'b0;
    exp_fetch = 32'd0;

    // Streaming after reset at latency 1.
    do_reset();
    hs_seen = 1'b0;
    repeat (12) step();
    chk("first_pc", first_hs_pc, 32'h0000_0000);

    // Decode stall: only DEPTH requests may be accepted.
    do_reset();
    p_dec = 0; n_acc = 0;
    repeat (10) step();
    chk("stall_req_cnt", n_acc, 32'd4);
    p_dec = 100;
    repeat (12) step();

    // Redirect with two requests in flight at latency 3.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    repeat (2) step();
    force_redir = 1'b1; force_pc = 32'h0000_0100;
    step();
    hs_seen = 1'b0;
    repeat (12) step();
    chk("redir_first_pc", first_hs_pc, 32'h0000_0100);

    // Redirect to the top of the address space.
    do_reset();
    lat_lo = 1; lat_hi = 1;
    force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
    step();
    hs_seen = 1'b0;
    repeat (8) step();
    chk("wrap_first_pc", first_hs_pc, 32'hFFFF_FFFC);

    // Random traffic, with a reset in the middle.
    do_reset();
    p_redir = 30; p_ready = 70; p_dec = 70; lat_lo = 1; lat_hi = 5;
    repeat (2500) step();
    do_reset();
    repeat (2500) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
